// File: rtl/ysyx_22041211_defines.sv
// Shared encodings for the decode stage: opcodes, ALU operand selects, ALU ops and
// skid-buffer states.
package ysyx_22041211_defines;

   localparam logic [6:0] OpcLui    = 7'b0110111;
   localparam logic [6:0] OpcAuipc  = 7'b0010111;
   localparam logic [6:0] OpcJal    = 7'b1101111;
   localparam logic [6:0] OpcJalr   = 7'b1100111;
   localparam logic [6:0] OpcBranch = 7'b1100011;
   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcOpImm  = 7'b0010011;
   localparam logic [6:0] OpcOp     = 7'b0110011;
   localparam logic [6:0] OpcSystem = 7'b1110011;

   localparam logic [31:0] InstEcall  = 32'h0000_0073;
   localparam logic [31:0] InstEbreak = 32'h0010_0073;

   // aluop = {src2_sel, src1_sel}
   localparam logic [1:0] Src1Reg  = 2'b00;
   localparam logic [1:0] Src1Pc   = 2'b01;
   localparam logic [1:0] Src1Zero = 2'b10;
   localparam logic [1:0] Src2Reg  = 2'b00;
   localparam logic [1:0] Src2Imm  = 2'b01;
   localparam logic [1:0] Src2Four = 2'b10;

   localparam logic [3:0] AluAdd  = 4'd0;
   localparam logic [3:0] AluSub  = 4'd1;
   localparam logic [3:0] AluSll  = 4'd2;
   localparam logic [3:0] AluSlt  = 4'd3;
   localparam logic [3:0] AluSltu = 4'd4;
   localparam logic [3:0] AluXor  = 4'd5;
   localparam logic [3:0] AluSrl  = 4'd6;
   localparam logic [3:0] AluSra  = 4'd7;
   localparam logic [3:0] AluOr   = 4'd8;
   localparam logic [3:0] AluAnd  = 4'd9;

   localparam logic [1:0] StEmpty = 2'd0;
   localparam logic [1:0] StOne   = 2'd1;
   localparam logic [1:0] StFull  = 2'd2;

   // alt is instruction bit 30: selects SUB over ADD and SRA over SRL
   function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
      case (f3)
         3'b000:  return alt ? AluSub : AluAdd;
         3'b001:  return AluSll;
         3'b010:  return AluSlt;
         3'b011:  return AluSltu;
         3'b100:  return AluXor;
         3'b101:  return alt ? AluSra : AluSrl;
         3'b110:  return AluOr;
         default: return AluAnd;
      endcase
   endfunction

endpackage

// File: rtl/ysyx_22041211_decode_core.sv
// Combinational RV32I/E decoder: picks immediate, ALU op and operand sources, and
// presents the already-muxed ALU operands.
module ysyx_22041211_decode_core
   import ysyx_22041211_defines::*;
#(
   parameter int unsigned NREG = 32,
   parameter int unsigned XLEN = 32
) (
   input  logic [31:0]     inst_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] reg1_data_i,
   input  logic [XLEN-1:0] reg2_data_i,
   output logic [4:0]      reg1_addr_o,
   output logic [4:0]      reg2_addr_o,
   output logic [3:0]      aluop_o,
   output logic [3:0]      alusel_o,
   output logic [XLEN-1:0] reg1_o,
   output logic [XLEN-1:0] reg2_o,
   output logic [XLEN-1:0] imm_o,
   output logic [4:0]      wreg_o,
   output logic            wd_o,
   output logic            reg1_read_o,
   output logic            reg2_read_o,
   output logic            illegal_o
);

   logic [6:0]  opcode, f7;
   logic [2:0]  f3;
   logic [4:0]  rd, rs1, rs2;
   logic [31:0] imm_i32, imm_s32, imm_b32, imm_u32, imm_j32, imm32;
   logic [1:0]  src1, src2;
   logic        wr_en, bad;

   assign opcode = inst_i[6:0];
   assign rd     = inst_i[11:7];
   assign f3     = inst_i[14:12];
   assign rs1    = inst_i[19:15];
   assign rs2    = inst_i[24:20];
   assign f7     = inst_i[31:25];

   assign imm_i32 = {{20{inst_i[31]}}, inst_i[31:20]};
   assign imm_s32 = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
   assign imm_b32 = {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
   assign imm_u32 = {inst_i[31:12], 12'b0};
   assign imm_j32 = {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

   assign reg1_addr_o = rs1;
   assign reg2_addr_o = rs2;
   assign wreg_o      = rd;

   always_comb begin
      src1        = Src1Reg;
      src2        = Src2Reg;
      alusel_o    = AluAdd;
      imm32       = '0;
      reg1_read_o = 1'b0;
      reg2_read_o = 1'b0;
      wr_en       = 1'b0;
      bad         = 1'b0;
      case (opcode)
         OpcLui, OpcAuipc: begin
            src1  = (opcode == OpcLui) ? Src1Zero : Src1Pc;
            src2  = Src2Imm;
            imm32 = imm_u32;
            wr_en = 1'b1;
         end
         OpcJal, OpcJalr: begin
            src1        = Src1Pc;
            src2        = Src2Four;
            imm32       = (opcode == OpcJal) ? imm_j32 : imm_i32;
            reg1_read_o = (opcode == OpcJalr);
            wr_en       = 1'b1;
            bad         = (opcode == OpcJalr) && (f3 != 3'b000);
         end
         OpcBranch: begin
            imm32       = imm_b32;
            reg1_read_o = 1'b1;
            reg2_read_o = 1'b1;
            case (f3[2:1])
               2'b00:   alusel_o = AluSub;
               2'b10:   alusel_o = AluSlt;
               2'b11:   alusel_o = AluSltu;
               default: bad = 1'b1;
            endcase
         end
         OpcLoad: begin
            src2        = Src2Imm;
            imm32       = imm_i32;
            reg1_read_o = 1'b1;
            wr_en       = 1'b1;
            bad         = (f3 == 3'b011) || (f3[2:1] == 2'b11);
         end
         OpcStore: begin
            src2        = Src2Imm;
            imm32       = imm_s32;
            reg1_read_o = 1'b1;
            reg2_read_o = 1'b1;
            bad         = f3[2] || (f3[1:0] == 2'b11);
         end
         OpcOpImm: begin
            src2        = Src2Imm;
            reg1_read_o = 1'b1;
            wr_en       = 1'b1;
            if (f3[1:0] == 2'b01) begin
               // shift-immediate: rs2 field carries shamt, func7 is an opcode extension
               imm32    = {27'b0, inst_i[24:20]};
               alusel_o = alu_from_f3(f3, inst_i[30]);
               bad      = (f3 == 3'b001) ? (f7 != 7'b0) : (f7 != 7'b0 && f7 != 7'b0100000);
            end else begin
               imm32    = imm_i32;
               alusel_o = alu_from_f3(f3, 1'b0);
            end
         end
         OpcOp: begin
            reg1_read_o = 1'b1;
            reg2_read_o = 1'b1;
            wr_en       = 1'b1;
            alusel_o    = alu_from_f3(f3, inst_i[30]);
            bad         = !((f7 == 7'b0) ||
                            (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)));
         end
         OpcSystem: bad = (inst_i != InstEcall) && (inst_i != InstEbreak);
         default:   bad = 1'b1;
      endcase

      // register fields beyond the architectural file (RV32E) are illegal
      if ((reg1_read_o && 32'(rs1) >= NREG) || (reg2_read_o && 32'(rs2) >= NREG) ||
          (wr_en && 32'(rd) >= NREG)) begin
         bad = 1'b1;
      end

      illegal_o = bad;
      wd_o      = wr_en && !bad && (rd != 5'd0);
      aluop_o   = {src2, src1};
      imm_o     = XLEN'($signed(imm32));

      case (src1)
         Src1Pc:   reg1_o = pc_i;
         Src1Zero: reg1_o = '0;
         default:  reg1_o = reg1_data_i;
      endcase
      case (src2)
         Src2Imm:  reg2_o = imm_o;
         Src2Four: reg2_o = XLEN'(4);
         default:  reg2_o = reg2_data_i;
      endcase
   end

endmodule

// File: rtl/ysyx_22041211_decode_stage.sv
// Decode pipeline stage: decode core followed by a 2-entry skid buffer so upstream
// ready never depends combinationally on downstream ready.
module ysyx_22041211_decode_stage
   import ysyx_22041211_defines::*;
#(
   parameter int unsigned NREG = 32,
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     inst_i,
   input  logic [XLEN-1:0] pc_i,
   output logic [4:0]      reg1_addr_o,
   output logic [4:0]      reg2_addr_o,
   input  logic [XLEN-1:0] reg1_data_i,
   input  logic [XLEN-1:0] reg2_data_i,
   input  logic            flush_i,
   output logic            out_valid_o,
   input  logic            out_ready_i,
   output logic [3:0]      aluop_o,
   output logic [3:0]      alusel_o,
   output logic [XLEN-1:0] reg1_o,
   output logic [XLEN-1:0] reg2_o,
   output logic [XLEN-1:0] imm_o,
   output logic [XLEN-1:0] pc_o,
   output logic [31:0]     inst_o,
   output logic [4:0]      wreg_o,
   output logic            wd_o,
   output logic            reg1_read_o,
   output logic            reg2_read_o,
   output logic            illegal_o
);

   localparam int unsigned EntW = 49 + 4 * XLEN;

   logic [3:0]      d_aluop, d_alusel;
   logic [XLEN-1:0] d_reg1, d_reg2, d_imm;
   logic [4:0]      d_wreg;
   logic            d_wd, d_reg1_read, d_reg2_read, d_illegal;
   logic [EntW-1:0] dec_entry, head_q, head_d, skid_q, skid_d;
   logic [1:0]      state_q, state_d;
   logic            accept, drain;

   ysyx_22041211_decode_core #(
      .NREG(NREG),
      .XLEN(XLEN)
   ) u_core (
      .inst_i      (inst_i),
      .pc_i        (pc_i),
      .reg1_data_i (reg1_data_i),
      .reg2_data_i (reg2_data_i),
      .reg1_addr_o (reg1_addr_o),
      .reg2_addr_o (reg2_addr_o),
      .aluop_o     (d_aluop),
      .alusel_o    (d_alusel),
      .reg1_o      (d_reg1),
      .reg2_o      (d_reg2),
      .imm_o       (d_imm),
      .wreg_o      (d_wreg),
      .wd_o        (d_wd),
      .reg1_read_o (d_reg1_read),
      .reg2_read_o (d_reg2_read),
      .illegal_o   (d_illegal)
   );

   assign dec_entry = {d_aluop, d_alusel, d_reg1, d_reg2, d_imm, pc_i, inst_i, d_wreg,
                       d_wd, d_reg1_read, d_reg2_read, d_illegal};
   assign {aluop_o, alusel_o, reg1_o, reg2_o, imm_o, pc_o, inst_o, wreg_o,
           wd_o, reg1_read_o, reg2_read_o, illegal_o} = head_q;

   assign in_ready_o  = (state_q != StFull);
   assign out_valid_o = (state_q != StEmpty);
   assign accept      = in_valid_i && in_ready_o;
   assign drain       = out_valid_o && out_ready_i;

   // head_q drives the outputs; skid_q only ever holds the younger instruction
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      skid_d  = skid_q;
      if (flush_i) begin
         state_d = StEmpty;
      end else begin
         case (state_q)
            StEmpty: begin
               if (accept) begin
                  head_d  = dec_entry;
                  state_d = StOne;
               end
            end
            StOne: begin
               if (accept && drain) begin
                  head_d = dec_entry;
               end else if (accept) begin
                  skid_d  = dec_entry;
                  state_d = StFull;
               end else if (drain) begin
                  state_d = StEmpty;
               end
            end
            StFull: begin
               if (drain) begin
                  head_d  = skid_q;
                  state_d = StOne;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StEmpty;
         head_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: tb/tb_ysyx_22041211_decode_stage.sv
// Bench for the decode stage: directed instructions through an NREG=32 and an NREG=16
// instance in lockstep, expected results queued at acceptance and popped at drain.
module tb_ysyx_22041211_decode_stage;

   typedef struct {
      logic [31:0] inst, pc, r1, r2, imm;
      logic [3:0]  aluop, alusel;
      logic [4:0]  wreg;
      logic [5:0]  flags;  // {wd, reg1_read, reg2_read, illegal, wd@NREG16, illegal@NREG16}
   } exp_t;

   logic        clk, rst_n, in_valid, flush, out_ready;
   logic [31:0] inst, pc_in;
   logic [4:0]  r1_addr, r2_addr, r1_addr16, r2_addr16;
   logic [31:0] r1_data, r2_data, r1_data16, r2_data16;
   logic        in_ready, out_valid;
   logic [3:0]  aluop, alusel;
   logic [31:0] reg1, reg2, imm, pc_out, inst_out;
   logic [4:0]  wreg;
   logic        wd, rd1, rd2, ill;
   logic        in_ready16, out_valid16, wd16, rd1_16, rd2_16, ill16;
   logic [3:0]  aluop16, alusel16;
   logic [31:0] reg1_16, reg2_16, imm16, pc16, inst16;
   logic [4:0]  wreg16;

   int          n_tests = 0;
   int          n_fail = 0;
   exp_t        q[$];
   logic [31:0] pc;

   function automatic logic [31:0] rf_val(input logic [4:0] a);
      case (a)
         5'd0:    return 32'd0;
         5'd1:    return 32'd7;
         5'd2:    return 32'd9;
         default: return 32'h1000_0000 + 32'(a);
      endcase
   endfunction

   assign r1_data   = rf_val(r1_addr);
   assign r2_data   = rf_val(r2_addr);
   assign r1_data16 = rf_val(r1_addr16);
   assign r2_data16 = rf_val(r2_addr16);

   ysyx_22041211_decode_stage #(.NREG(32), .XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .inst_i(inst), .pc_i(pc_in), .reg1_addr_o(r1_addr), .reg2_addr_o(r2_addr),
      .reg1_data_i(r1_data), .reg2_data_i(r2_data), .flush_i(flush),
      .out_valid_o(out_valid), .out_ready_i(out_ready), .aluop_o(aluop), .alusel_o(alusel),
      .reg1_o(reg1), .reg2_o(reg2), .imm_o(imm), .pc_o(pc_out), .inst_o(inst_out),
      .wreg_o(wreg), .wd_o(wd), .reg1_read_o(rd1), .reg2_read_o(rd2), .illegal_o(ill)
   );

   ysyx_22041211_decode_stage #(.NREG(16), .XLEN(32)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready16),
      .inst_i(inst), .pc_i(pc_in), .reg1_addr_o(r1_addr16), .reg2_addr_o(r2_addr16),
      .reg1_data_i(r1_data16), .reg2_data_i(r2_data16), .flush_i(flush),
      .out_valid_o(out_valid16), .out_ready_i(out_ready), .aluop_o(aluop16),
      .alusel_o(alusel16), .reg1_o(reg1_16), .reg2_o(reg2_16), .imm_o(imm16), .pc_o(pc16),
      .inst_o(inst16), .wreg_o(wreg16), .wd_o(wd16), .reg1_read_o(rd1_16),
      .reg2_read_o(rd2_16), .illegal_o(ill16)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   function automatic exp_t mk(input logic [31:0] i, input logic [3:0] op, input logic [3:0] sel,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] im, input logic [4:0] w,
                               input logic [5:0] f);
      exp_t e;
      e.inst = i; e.pc = '0; e.r1 = a; e.r2 = b; e.imm = im;
      e.aluop = op; e.alusel = sel; e.wreg = w; e.flags = f;
      return e;
   endfunction

   // Holds the instruction until accepted, then queues its expected decode.
   task automatic send(input exp_t e_in);
      exp_t e;
      bit   acc;
      bit   done;
      e        = e_in;
      e.pc     = pc;
      done     = 1'b0;
      in_valid = 1'b1;
      inst     = e.inst;
      pc_in    = pc;
      for (int k = 0; k < 20 && !done; k++) begin
         acc = in_ready;
         @(posedge clk);
         #2;
         if (acc) begin
            q.push_back(e);
            done = 1'b1;
         end
      end
      in_valid = 1'b0;
      pc       = pc + 32'd4;
      chk("accept_within_budget", 32'(done), 32'd1);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (rst_n && out_valid && out_ready) begin
         n_tests++;
         assert (q.size() != 0) else begin
            n_fail++;
            $error("FAIL unexpected_output: got inst %h, expected nothing", inst_out);
         end
         if (q.size() != 0) begin
            e = q.pop_front();
            chk("inst", inst_out, e.inst);
            chk("pc", pc_out, e.pc);
            chk("aluop", 32'(aluop), 32'(e.aluop));
            chk("alusel", 32'(alusel), 32'(e.alusel));
            chk("reg1", reg1, e.r1);
            chk("reg2", reg2, e.r2);
            chk("imm", imm, e.imm);
            chk("wreg", 32'(wreg), 32'(e.wreg));
            chk("flags", {26'b0, wd, rd1, rd2, ill, wd16, ill16}, {26'b0, e.flags});
         end
      end
   end

   initial begin
      exp_t add3, lui5, sub4, addi6, srai7, beq, jal, sw, bad, mul, ecall, addx0, add17;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      flush     = 1'b0;
      out_ready = 1'b1;
      inst      = '0;
      pc_in     = '0;
      pc        = 32'h8000_0000;

      add3  = mk(32'h002081B3, 4'h0, 4'd0, 32'd7, 32'd9, 32'd0, 5'd3, 6'b111010);
      lui5  = mk(32'h123452B7, 4'h6, 4'd0, 32'd0, 32'h12345000, 32'h12345000, 5'd5, 6'b100010);
      sub4  = mk(32'h40208233, 4'h0, 4'd1, 32'd7, 32'd9, 32'd0, 5'd4, 6'b111010);
      addi6 = mk(32'hFFF08313, 4'h4, 4'd0, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 6'b110010);
      srai7 = mk(32'h4030D393, 4'h4, 4'd7, 32'd7, 32'd3, 32'd3, 5'd7, 6'b110010);
      beq   = mk(32'h00208863, 4'h0, 4'd1, 32'd7, 32'd9, 32'd16, 5'd16, 6'b011000);
      sw    = mk(32'h0020A223, 4'h4, 4'd0, 32'd7, 32'd4, 32'd4, 5'd4, 6'b011000);
      bad   = mk(32'hFFFFFFFF, 4'h0, 4'd0, 32'h1000001F, 32'h1000001F, 32'd0, 5'd31, 6'b000101);
      mul   = mk(32'h02208233, 4'h0, 4'd0, 32'd7, 32'd9, 32'd0, 5'd4, 6'b011101);
      ecall = mk(32'h00000073, 4'h0, 4'd0, 32'd0, 32'd0, 32'd0, 5'd0, 6'b000000);
      addx0 = mk(32'h00208033, 4'h0, 4'd0, 32'd7, 32'd9, 32'd0, 5'd0, 6'b011000);
      add17 = mk(32'h002088B3, 4'h0, 4'd0, 32'd7, 32'd9, 32'd0, 5'd17, 6'b111001);

      // reset state, no clock edge yet
      #3;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_inst_o", inst_out, 32'd0);
      chk("rst_reg1_o", reg1, 32'd0);
      chk("rst_aluop", 32'(aluop), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #2;

      inst = add3.inst;
      #1;
      chk("reg1_addr_comb", 32'(r1_addr), 32'd1);
      chk("reg2_addr_comb", 32'(r2_addr), 32'd2);

      // streaming with downstream always ready
      send(add3);
      chk("latency_one_cycle", 32'(out_valid), 32'd1);
      send(lui5);
      send(sub4);
      send(addi6);
      send(srai7);
      send(beq);
      jal = mk(32'h008000EF, 4'h9, 4'd0, pc, 32'd4, 32'd8, 5'd1, 6'b100010);
      send(jal);
      send(sw);
      send(bad);
      send(mul);
      send(ecall);
      send(addx0);
      send(add17);
      repeat (3) @(posedge clk);
      #2;
      chk("stream_drained", 32'(q.size()), 32'd0);

      // skid: fill both entries while stalled, third waits
      out_ready = 1'b0;
      send(add3);
      send(lui5);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      in_valid = 1'b1;
      inst     = sub4.inst;
      pc_in    = pc;
      @(posedge clk);
      #2;
      chk("full_hold_in_ready", 32'(in_ready), 32'd0);
      chk("stall_head_stable", inst_out, add3.inst);
      out_ready = 1'b1;
      send(sub4);
      repeat (3) @(posedge clk);
      #2;
      chk("skid_drained", 32'(q.size()), 32'd0);

      // flush while full, with a same-cycle offer
      out_ready = 1'b0;
      send(addi6);
      send(srai7);
      chk("pre_flush_full", 32'(in_ready), 32'd0);
      in_valid = 1'b1;
      inst     = beq.inst;
      flush    = 1'b1;
      @(posedge clk);
      #2;
      flush    = 1'b0;
      in_valid = 1'b0;
      q.delete();
      chk("flush_out_valid", 32'(out_valid), 32'd0);
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #2;
      chk("flush_nothing_delivered", 32'(out_valid), 32'd0);

      // asynchronous reset while holding one entry
      out_ready = 1'b0;
      send(addi6);
      chk("one_out_valid", 32'(out_valid), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_out_valid", 32'(out_valid), 32'd0);
      chk("async_rst_in_ready", 32'(in_ready), 32'd1);
      chk("async_rst_inst_o", inst_out, 32'd0);
      chk("async_rst_wd", 32'(wd), 32'd0);
      q.delete();
      @(negedge clk);
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #2;
      send(sub4);
      chk("post_rst_latency", 32'(out_valid), 32'd1);

      for (int k = 0; k < 20 && q.size() != 0; k++) @(posedge clk);
      #2;
      chk("queue_empty_at_end", 32'(q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
